sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the 8x8 sync FIFO.
//  Adds generic width/depth, flush, programmable almost-full/empty, an occupancy output,
//    a registered read with valid strobe, and sticky overflow/underflow flags.
//  Buffers streams between producer/consumer blocks in one clock domain.
// PARAMETERS
//  DATA_W     8  data width in bits (>=1)
//  DEPTH      8  number of entries; power of 2, >=2 (elaborate-time check, $fatal otherwise)
//  AF_THRESH  6  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  1  almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1                 clock; all logic on posedge
//  rst           in   1                 synchronous reset, active-high
//  flush         in   1                 synchronous clear of contents (pointers/count)
//  wr_en         in   1                 write request
//  data_input    in   DATA_W            write data
//  rd_en         in   1                 read request
//  data_out      out  DATA_W            read data, registered
//  rd_valid      out  1                 data_out updated this cycle (1-cycle pulse)
//  full          out  1                 count == DEPTH
//  empty         out  1                 count == 0
//  almost_full   out  1                 count >= AF_THRESH
//  almost_empty  out  1                 count <= AE_THRESH
//  count         out  $clog2(DEPTH)+1   current occupancy
//  overflow      out  1                 sticky: write attempted while full
//  underflow     out  1                 sticky: read attempted while empty
//  clr_err       in   1                 clears overflow/underflow
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, data_out=0, rd_valid=0,
//    overflow=underflow=0 -> empty=1, full=0, almost_empty=1, almost_full=0. Memory not cleared.
//  - Priority per cycle: rst > flush > rd/wr.
//  - wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty; both evaluated on pre-edge flags.
//  - wr_acc: mem[wr_ptr] <= data_input; wr_ptr += 1, wrapping modulo DEPTH (ptr width $clog2(DEPTH)).
//  - rd_acc: data_out <= mem[rd_ptr] next edge; rd_valid=1 that next cycle; rd_ptr += 1 (wraps).
//    Read latency 1 cycle from rd_acc. Without rd_acc, data_out holds and rd_valid=0.
//  - count update uses accepted ops only: +1 on wr_acc only, -1 on rd_acc only,
//    unchanged on both or neither. Never exceeds DEPTH; never below 0.
//  - Simultaneous rd/wr:
//    - non-empty/non-full: both proceed, count unchanged.
//    - full: read proceeds, write is rejected and flags overflow (no write-through).
//    - empty: write proceeds, read is rejected and flags underflow (no fall-through).
//  - Status flags are combinational decodes of the registered count only.
//  - overflow set on wr_en & full; underflow set on rd_en & empty.
//    Both held until clr_err or rst. Set has priority over clr_err in the same cycle.
//  - flush: pointers and count -> 0, rd_valid -> 0; data_out holds; error flags unaffected.
//    Concurrent rd/wr ignored.
//  - Reset or flush mid-stream discards all entries; next write lands at mem[0].
// STRUCTURE
//  - Package sync_fifo_pkg: function ptr_w(depth)=$clog2(depth); localparam CNT_W rule.
//  - Sub-module sync_fifo_ram: DEPTH x DATA_W, one write port (we, waddr, wdata),
//    one registered read port (re, raddr, rdata). Top keeps pointers, count, flags and errors.
// TESTING
//  - Reset: hold rst 2 cycles -> empty=1, count=0, data_out=0, rd_valid=0, overflow=underflow=0.
//  - Fill/drain (defaults): write 0..7 -> full=1, almost_full from count 6.
//    Then read 8 -> data_out 0..7 in order, each 1 cycle after rd_en, with rd_valid; empty=1 at end.
//  - Wrap: write 5, read 5, write 8, read 8 -> order preserved across wrap; count never >8.
//  - Boundary concurrency:
//    - full, wr_en=rd_en=1 -> one read, write dropped, overflow=1, count=7.
//    - empty, both=1 -> write kept, underflow=1, count=1.
//  - Errors/flush: pulse clr_err -> flags 0. Write 3 then flush with wr_en=1 -> count=0, empty=1.
//    Next write+read returns the new data.
//  - Params: DATA_W=16, DEPTH=32, AF=30, AE=2 -> almost_full at count 30, almost_empty at count<=2;
//    full at 32; 16-bit data intact.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  // Pointer width: enough bits to address DEPTH entries.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so the value DEPTH itself is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W storage: one write port, one registered read port.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register doubles as the FIFO's data_out; it holds when re is low.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with flush, programmable thresholds,
// registered read with valid strobe and sticky overflow/underflow flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         data_input,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         data_out,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (DATA_W < 1) begin : g_bad_width
    $fatal(1, "sync_fifo_param: DATA_W must be >= 1");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic          ram_we;
  logic          ram_re;

  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (count >= CW'(AF_THRESH));
    almost_empty = (count <= CW'(AE_THRESH));
    wr_acc       = wr_en & ~full;
    rd_acc       = rd_en & ~empty;
    // Flush suppresses both ports so no stale entry is written or read out.
    ram_we       = wr_acc & ~flush & ~rst;
    ram_re       = rd_acc & ~flush & ~rst;
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (data_input),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Error flags are independent of flush; a new set wins over clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      else if (clr_err)   overflow  <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default 8x8 instance plus a 16x32 instance.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, flush = 1'b0, clr_err = 1'b0;

  logic       a_wr = 1'b0, a_rd = 1'b0;
  logic [7:0] a_din = '0, a_dout;
  logic       a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0] a_cnt;

  logic        b_wr = 1'b0, b_rd = 1'b0;
  logic [15:0] b_din = '0, b_dout;
  logic        b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [5:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  sync_fifo_param u_a (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(a_wr), .data_input(a_din),
    .rd_en(a_rd), .data_out(a_dout), .rd_valid(a_rv), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_unf), .clr_err(clr_err)
  );

  sync_fifo_param #(
    .DATA_W(16), .DEPTH(32), .AF_THRESH(30), .AE_THRESH(2)
  ) u_b (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(b_wr), .data_input(b_din),
    .rd_en(b_rd), .data_out(b_dout), .rd_valid(b_rv), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_unf), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] v);
    a_wr = 1'b1; a_din = v; tick(); a_wr = 1'b0;
  endtask

  task automatic a_read_expect(input string tag, input logic [7:0] v);
    a_rd = 1'b1; tick(); a_rd = 1'b0;
    check({tag, "_rv"}, a_rv, 1);
    check({tag, "_data"}, a_dout, v);
  endtask

  initial begin
    // Reset held two cycles
    tick(); tick();
    rst = 1'b0;
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_count", a_cnt, 0);
    check("rst_dout", a_dout, 0);
    check("rst_rv", a_rv, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_unf", a_unf, 0);
    check("rst_ae", a_ae, 1);
    check("rst_af", a_af, 0);

    // Fill 0..7
    for (int i = 0; i < 8; i++) begin
      a_write(8'(i));
      check("fill_count", a_cnt, 32'(i + 1));
      check("fill_af", a_af, (i + 1 >= 6) ? 1 : 0);
      check("fill_ae", a_ae, (i + 1 <= 1) ? 1 : 0);
      check("fill_full", a_full, (i + 1 == 8) ? 1 : 0);
    end
    // Drain in order
    for (int i = 0; i < 8; i++) begin
      a_read_expect("drain", 8'(i));
      check("drain_count", a_cnt, 32'(7 - i));
    end
    tick();
    check("drain_rv_idle", a_rv, 0);
    check("drain_hold", a_dout, 8'd7);
    check("drain_empty", a_empty, 1);
    check("drain_unf", a_unf, 0);

    // Wrap: 5 in/out, then 8 in/out
    for (int i = 0; i < 5; i++) a_write(8'(8'h10 + i));
    for (int i = 0; i < 5; i++) a_read_expect("wrap5", 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) begin
      a_write(8'(8'h20 + i));
      check("wrap_cnt", a_cnt, 32'(i + 1));
    end
    check("wrap_full", a_full, 1);
    for (int i = 0; i < 8; i++) a_read_expect("wrap8", 8'(8'h20 + i));
    check("wrap_empty", a_empty, 1);

    // Full with simultaneous read/write: write dropped, overflow set
    for (int i = 0; i < 8; i++) a_write(8'(8'h30 + i));
    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h99; tick(); a_wr = 1'b0; a_rd = 1'b0;
    check("fullrw_rv", a_rv, 1);
    check("fullrw_data", a_dout, 8'h30);
    check("fullrw_count", a_cnt, 7);
    check("fullrw_ovf", a_ovf, 1);
    for (int i = 1; i < 8; i++) a_read_expect("fullrw_rest", 8'(8'h30 + i));
    check("fullrw_empty", a_empty, 1);

    // Empty with simultaneous read/write: read rejected, underflow set
    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h55; tick(); a_wr = 1'b0; a_rd = 1'b0;
    check("emptyrw_rv", a_rv, 0);
    check("emptyrw_hold", a_dout, 8'h37);
    check("emptyrw_count", a_cnt, 1);
    check("emptyrw_unf", a_unf, 1);
    check("emptyrw_ovf_sticky", a_ovf, 1);
    a_read_expect("emptyrw_kept", 8'h55);

    // Clear error flags
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_ovf", a_ovf, 0);
    check("clr_unf", a_unf, 0);

    // Flush with concurrent write
    a_write(8'h01); a_write(8'h02); a_write(8'h03);
    check("preflush_cnt", a_cnt, 3);
    flush = 1'b1; a_wr = 1'b1; a_din = 8'h77; tick(); flush = 1'b0; a_wr = 1'b0;
    check("flush_count", a_cnt, 0);
    check("flush_empty", a_empty, 1);
    check("flush_rv", a_rv, 0);
    check("flush_hold", a_dout, 8'h55);
    a_write(8'hA5);
    check("postflush_cnt", a_cnt, 1);
    a_read_expect("postflush", 8'hA5);

    // Second instance: 16-bit x 32, AF=30, AE=2
    check("b_empty0", b_empty, 1);
    for (int i = 0; i < 32; i++) begin
      b_wr = 1'b1; b_din = 16'(16'h1000 + i * 16'h0101); tick(); b_wr = 1'b0;
      check("b_cnt", b_cnt, 32'(i + 1));
      check("b_af", b_af, (i + 1 >= 30) ? 1 : 0);
      check("b_ae", b_ae, (i + 1 <= 2) ? 1 : 0);
      check("b_full", b_full, (i + 1 == 32) ? 1 : 0);
    end
    for (int i = 0; i < 32; i++) begin
      b_rd = 1'b1; tick(); b_rd = 1'b0;
      check("b_rv", b_rv, 1);
      check("b_data", b_dout, 32'(16'(16'h1000 + i * 16'h0101)));
    end
    check("b_empty_end", b_empty, 1);
    check("b_unf", b_unf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
